// File: rtl/adc733_codec_emu.sv
// AD73311-style serial codec emulator: SCLK generator, framed 16-bit transmitter, control receiver.
// Optional macro ADC733_CODEC_EMU_ECHO_EN: program-mode frames echo the last accepted control word.
module adc733_codec_emu #(
    parameter int SCLK_DIV    = 2,
    parameter int FRAME_SCLKS = 128,
    parameter int NCH         = 6
) (
    input  logic        clk,
    input  logic        rst,
    output logic        SCLK,
    output logic        SDOFS,
    output logic        SDO,
    input  logic        SDIFS,
    input  logic        SDI,
    input  logic        SE,
    input  logic [15:0] smp_data,
    output logic [2:0]  smp_ch,
    output logic        smp_rd,
    output logic        data_mode,
    output logic [63:0] regs
);

    localparam int HALF       = SCLK_DIV / 2;
    localparam int DW         = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int FW         = ($clog2(FRAME_SCLKS) > 7) ? $clog2(FRAME_SCLKS) : 7;
    localparam int DATA_SCLKS = 16 * NCH;

    logic [DW-1:0] r_div;
    logic          r_sclk;
    logic [FW-1:0] r_fcnt;
    logic [15:0]   r_tx_sh;
    logic          r_sdo;
    logic          r_sdofs;
    logic          r_rx_busy;
    logic [3:0]    r_rx_cnt;
    logic [15:0]   r_rx_sh;
    logic          r_rx_vld;
    logic [15:0]   r_rx_word;
    logic [63:0]   r_regs;
    logic          r_data_mode;
    logic          r_mode_pend;

    logic          w_tick;
    logic          w_rise;
    logic          w_fall;
    logic          w_fstart;
    logic          w_dm;
    logic          w_in_word;
    logic          w_load;
    logic [15:0]   w_prog_word;
    logic [15:0]   w_word;

    assign w_tick   = (r_div == DW'(HALF - 1));
    assign w_rise   = w_tick & ~r_sclk;
    assign w_fall   = w_tick & r_sclk;
    assign w_fstart = w_rise && (r_fcnt == '0);

    // The frame that starts as data mode takes effect must already be framed as data mode.
    assign w_dm      = r_data_mode | (w_fstart & r_mode_pend);
    assign w_in_word = w_dm ? (r_fcnt < FW'(DATA_SCLKS)) : (r_fcnt < FW'(16));
    assign w_load    = w_rise & w_in_word & (r_fcnt[3:0] == 4'd0);

    assign smp_rd = w_load & w_dm;
    assign smp_ch = (w_dm & w_in_word) ? r_fcnt[6:4] : 3'd0;

`ifdef ADC733_CODEC_EMU_ECHO_EN
    logic [15:0] r_echo;
    assign w_prog_word = r_echo;
`else
    logic w_unused;
    assign w_unused    = ^r_rx_word[13:11];
    assign w_prog_word = 16'h0000;
`endif

    assign w_word = w_dm ? smp_data : w_prog_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_fcnt  <= '0;
            r_tx_sh <= 16'h0000;
            r_sdo   <= 1'b0;
            r_sdofs <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DW'(1);
            if (w_tick) begin
                r_sclk <= ~r_sclk;
            end
            if (w_rise) begin
                r_fcnt <= (r_fcnt == FW'(FRAME_SCLKS - 1)) ? '0 : r_fcnt + FW'(1);
                if (!SE || !w_in_word) begin
                    r_sdo   <= 1'b0;
                    r_sdofs <= 1'b0;
                    r_tx_sh <= 16'h0000;
                end else if (r_fcnt[3:0] == 4'd0) begin
                    r_sdo   <= w_word[15];
                    r_sdofs <= 1'b1;
                    r_tx_sh <= {w_word[14:0], 1'b0};
                end else begin
                    r_sdo   <= r_tx_sh[15];
                    r_sdofs <= 1'b0;
                    r_tx_sh <= {r_tx_sh[14:0], 1'b0};
                end
            end
        end
    end

    // SE low aborts any word in progress on every clk, not just on fall events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_busy <= 1'b0;
            r_rx_cnt  <= 4'd0;
            r_rx_sh   <= 16'h0000;
            r_rx_vld  <= 1'b0;
            r_rx_word <= 16'h0000;
        end else begin
            r_rx_vld <= 1'b0;
            if (!SE) begin
                r_rx_busy <= 1'b0;
            end else if (w_fall) begin
                if (!r_rx_busy) begin
                    if (SDIFS) begin
                        r_rx_busy <= 1'b1;
                        r_rx_sh   <= {15'h0000, SDI};
                        r_rx_cnt  <= 4'd1;
                    end
                end else begin
                    r_rx_sh <= {r_rx_sh[14:0], SDI};
                    if (r_rx_cnt == 4'd15) begin
                        r_rx_busy <= 1'b0;
                        r_rx_vld  <= 1'b1;
                        r_rx_word <= {r_rx_sh[14:0], SDI};
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs      <= 64'h0;
            r_data_mode <= 1'b0;
            r_mode_pend <= 1'b0;
`ifdef ADC733_CODEC_EMU_ECHO_EN
            r_echo      <= 16'h0000;
`endif
        end else begin
            if (w_fstart && r_mode_pend) begin
                r_data_mode <= 1'b1;
                r_mode_pend <= 1'b0;
            end
            if (r_rx_vld && r_rx_word[14] && !r_data_mode) begin
                r_regs[{r_rx_word[10:8], 3'b000} +: 8] <= r_rx_word[7:0];
`ifdef ADC733_CODEC_EMU_ECHO_EN
                r_echo <= r_rx_word;
`endif
                if (r_rx_word[15]) begin
                    r_mode_pend <= 1'b1;
                end
            end
        end
    end

    assign SCLK      = r_sclk;
    assign SDOFS     = r_sdofs;
    assign SDO       = r_sdo;
    assign data_mode = r_data_mode;
    assign regs      = r_regs;

endmodule

// File: tb/tb_adc733_codec_emu.sv
// Directed bench for adc733_codec_emu at default parameters (SCLK_DIV=2, 128 SCLKs/frame, 6 ch).
module tb_adc733_codec_emu;

    logic        clk = 1'b0;
    logic        rst;
    logic        SCLK, SDOFS, SDO;
    logic        SDIFS, SDI, SE;
    logic [15:0] smp_data;
    logic [2:0]  smp_ch;
    logic        smp_rd, data_mode;
    logic [63:0] regs;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef ADC733_CODEC_EMU_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    adc733_codec_emu dut (
        .clk       (clk),
        .rst       (rst),
        .SCLK      (SCLK),
        .SDOFS     (SDOFS),
        .SDO       (SDO),
        .SDIFS     (SDIFS),
        .SDI       (SDI),
        .SE        (SE),
        .smp_data  (smp_data),
        .smp_ch    (smp_ch),
        .smp_rd    (smp_rd),
        .data_mode (data_mode),
        .regs      (regs)
    );

    always #5 clk = ~clk;

    assign smp_data = {13'h0000, smp_ch};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_fail++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // Drive the first n bits of w so each is stable across a fall event.
    task automatic send_bits(input logic [15:0] w, input int n);
        int g;
        for (int i = 0; i < n; i++) begin
            g = 0;
            @(negedge clk);
            while (SCLK !== 1'b1 && g < 10) begin
                @(negedge clk);
                g++;
            end
            SDIFS = (i == 0);
            SDI   = w[15-i];
            @(posedge clk);
        end
        @(negedge clk);
        SDIFS = 1'b0;
        SDI   = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_bits(w, 16);
        @(negedge clk);
    endtask

    task automatic capture_word(input string tag, output logic [15:0] w);
        int g;
        w = 16'h0000;
        g = 0;
        while (SDOFS === 1'b1 && g < 10) begin
            @(negedge clk);
            g++;
        end
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(SCLK === 1'b1 && SDOFS === 1'b1) && g < 600);
        if (g >= 600) begin
            timeout(tag);
        end else begin
            w[15] = SDO;
            for (int b = 14; b >= 0; b--) begin
                do @(negedge clk); while (SCLK !== 1'b1);
                w[b] = SDO;
            end
        end
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] dw [6];
        int          rises;
        int          viol;
        int          nrd;
        int          rr;
        int          g;
        logic        prev_dm;
        logic [63:0] exp_regs;

        rst   = 1'b1;
        SE    = 1'b1;
        SDIFS = 1'b0;
        SDI   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sclk", SCLK, 0);
        check("rst_sdofs", SDOFS, 0);
        check("rst_sdo", SDO, 0);
        check("rst_smp_rd", smp_rd, 0);
        check("rst_data_mode", data_mode, 0);
        check("rst_smp_ch", smp_ch, 0);
        check("rst_regs", regs, 0);

        rst = 1'b0;
        @(negedge clk);
        check("first_rise_sclk", SCLK, 1);
        check("first_rise_sdofs", SDOFS, 1);

        rises = 0;
        g = 0;
        while (g < 600) begin
            @(negedge clk);
            g++;
            if (SCLK === 1'b1) begin
                rises++;
                if (SDOFS === 1'b1) break;
            end
        end
        check("frame_period", rises, 128);

        capture_word("prog_word_reset", w);
        check("prog_word_reset", w, 16'h0000);

        exp_regs = 64'h0;
        for (int i = 0; i < 8; i++) begin
            send_word(16'h4000 | (16'(i) << 8) | 16'(i));
            if (i == 3) check("regs_after_4", regs, 64'h0000_0000_0302_0100);
        end
        exp_regs = 64'h0706_0504_0302_0100;
        check("regs_all_8", regs, exp_regs);
        check("dm_prog", data_mode, 0);

        send_word(16'h0344);
        check("wr0_discard", regs, exp_regs);

        send_word(16'h4155);
        exp_regs = 64'h0706_0504_0302_5500;
        check("regs_4155", regs, exp_regs);
        capture_word("echo_word", w);
        check("echo_word", w, ECHO ? 16'h4155 : 16'h0000);

        send_bits(16'h4233, 5);
        SE = 1'b0;
        repeat (4) @(negedge clk);
        viol = 0;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (SDO !== 1'b0 || SDOFS !== 1'b0) viol++;
        end
        check("se_low_quiet", viol, 0);
        SE = 1'b1;
        @(negedge clk);
        check("se_abort_noreg", regs, exp_regs);
        capture_word("echo_after_abort", w);
        check("echo_after_abort", w, ECHO ? 16'h4155 : 16'h0000);

        repeat (20) @(negedge clk);
        send_word(16'hC108);
        exp_regs = 64'h0706_0504_0302_0800;
        check("mode_word_reg", regs, exp_regs);
        check("dm_not_midframe", data_mode, 0);

        g = 0;
        prev_dm = data_mode;
        @(negedge clk);
        while (!(SCLK === 1'b1 && SDOFS === 1'b1) && g < 600) begin
            prev_dm = data_mode;
            @(negedge clk);
            g++;
        end
        if (g >= 600) timeout("dm_frame_start");
        check("dm_at_frame_start", {prev_dm, data_mode}, 2'b01);

        // Current negedge is just after rise 0 of the first data-mode frame.
        nrd = 0;
        viol = 0;
        rr = 0;
        for (int k = 0; k < 6; k++) dw[k] = 16'h0000;
        for (int j = 0; j < 256; j++) begin
            if (j > 0) @(negedge clk);
            if (smp_rd === 1'b1) nrd++;
            if (SCLK === 1'b1) begin
                if (rr < 96) dw[rr/16] = {dw[rr/16][14:0], SDO};
                else if (SDO !== 1'b0) viol++;
                if (SDOFS !== ((rr < 96) && (rr % 16 == 0))) viol++;
                rr++;
            end
        end
        for (int k = 0; k < 6; k++) check($sformatf("data_word_%0d", k), dw[k], 64'(k));
        check("smp_rd_count", nrd, 6);
        check("data_frame_framing", viol, 0);

        send_word(16'h4377);
        check("dm_discard", regs, exp_regs);
        check("dm_sticky", data_mode, 1);

        rst = 1'b1;
        @(negedge clk);
        check("rst2_data_mode", data_mode, 0);
        check("rst2_regs", regs, 0);
        check("rst2_sdo", SDO, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
